muldiv_unit: RTL and testbench

Iterative multiply/divide sequencer owning the MIPS HI/LO register pair. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from the execute stage through a start/busy/done handshake. Each operation runs a 32-iteration shift-add or restoring-divide loop over a shared 64-bit working register. The unit sits beside the single-cycle ALU and takes over the operations that ALU leaves as placeholders. The pipeline controller stalls MFHI/MFLO on `busy`.

---
 rtl/muldiv_unit_if.sv | 21 ++
 rtl/muldiv_unit.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// ============================================================================
//  muldiv_unit_if : start/busy/done handshake and HI/LO read port
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_unit_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, op, a, b, input busy, done, hi, lo);
   modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
//  muldiv_unit : iterative 32-step MULT/MULTU/DIV/DIVU sequencer owning HI/LO
//  Optional divider built only when MULDIV_DIV_EN is defined.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit (
   input  logic           clk,
   input  logic           rst_n,
   muldiv_unit_if.slave   bus
);

   localparam logic [2:0] c_OP_MULT  = 3'b000;
   localparam logic [2:0] c_OP_MULTU = 3'b001;
   localparam logic [2:0] c_OP_DIV   = 3'b010;
   localparam logic [2:0] c_OP_DIVU  = 3'b011;
   localparam logic [2:0] c_OP_MTHI  = 3'b100;
   localparam logic [2:0] c_OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2} state_t;

   state_t      r_state;
   logic [4:0]  r_cnt;
   logic [63:0] r_acc;
   logic [31:0] r_opnd;
   logic        r_neg_res;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   // Opcodes with op[0]==0 (MULT, DIV) are the signed variants
   logic        w_is_signed;
   logic        w_a_neg;
   logic        w_b_neg;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [32:0] w_mul_sum;
   logic [63:0] w_mul_next;
   logic [63:0] w_prod_neg;

   assign w_is_signed = ~bus.op[0];
   assign w_a_neg     = w_is_signed & bus.a[31];
   assign w_b_neg     = w_is_signed & bus.b[31];
   assign w_a_mag     = w_a_neg ? (32'd0 - bus.a) : bus.a;
   assign w_b_mag     = w_b_neg ? (32'd0 - bus.b) : bus.b;

   // Accumulator holds {partial product, remaining multiplier bits}
   assign w_mul_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
   assign w_mul_next  = {w_mul_sum, r_acc[31:1]};
   assign w_prod_neg  = 64'd0 - r_acc;

`ifdef MULDIV_DIV_EN
   logic        r_is_div;
   logic        r_div0;
   logic        r_neg_rem;
   logic [31:0] r_a_raw;

   // Accumulator holds {remainder, dividend bits shifting into quotient}
   logic [32:0] w_rem_sh;
   logic [31:0] w_rem_diff;
   logic        w_rem_ge;
   logic [63:0] w_div_next;
   logic [31:0] w_q_neg;
   logic [31:0] w_r_neg;

   assign w_rem_sh   = r_acc[63:31];
   assign w_rem_diff = w_rem_sh[31:0] - r_opnd;
   assign w_rem_ge   = (w_rem_sh >= {1'b0, r_opnd});
   assign w_div_next = {(w_rem_ge ? w_rem_diff : w_rem_sh[31:0]), r_acc[30:0], w_rem_ge};
   assign w_q_neg    = 32'd0 - r_acc[31:0];
   assign w_r_neg    = 32'd0 - r_acc[63:32];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= 5'd0;
         r_acc     <= 64'd0;
         r_opnd    <= 32'd0;
         r_neg_res <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
`ifdef MULDIV_DIV_EN
         r_is_div  <= 1'b0;
         r_div0    <= 1'b0;
         r_neg_rem <= 1'b0;
         r_a_raw   <= 32'd0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  case (bus.op)
                     c_OP_MTHI: begin
                        r_hi   <= bus.a;
                        r_done <= 1'b1;
                     end
                     c_OP_MTLO: begin
                        r_lo   <= bus.a;
                        r_done <= 1'b1;
                     end
                     c_OP_MULT, c_OP_MULTU: begin
                        r_acc     <= {32'd0, w_b_mag};
                        r_opnd    <= w_a_mag;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_cnt     <= 5'd0;
                        r_busy    <= 1'b1;
                        r_state   <= S_CALC;
`ifdef MULDIV_DIV_EN
                        r_is_div  <= 1'b0;
`endif
                     end
                     c_OP_DIV, c_OP_DIVU: begin
`ifdef MULDIV_DIV_EN
                        r_acc     <= {32'd0, w_a_mag};
                        r_opnd    <= w_b_mag;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_div0    <= (bus.b == 32'd0);
                        r_a_raw   <= bus.a;
                        r_is_div  <= 1'b1;
                        r_cnt     <= 5'd0;
                        r_busy    <= 1'b1;
                        r_state   <= S_CALC;
`else
                        r_hi   <= 32'd0;
                        r_lo   <= 32'd0;
                        r_done <= 1'b1;
`endif
                     end
                     default: ;
                  endcase
               end
            end
            S_CALC: begin
`ifdef MULDIV_DIV_EN
               r_acc <= r_is_div ? w_div_next : w_mul_next;
`else
               r_acc <= w_mul_next;
`endif
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == 5'd31)
                  r_state <= S_FIX;
            end
            S_FIX: begin
`ifdef MULDIV_DIV_EN
               if (r_is_div) begin
                  // Divide-by-zero reports the raw dividend, bypassing sign fixup
                  if (r_div0) begin
                     r_hi <= r_a_raw;
                     r_lo <= 32'hFFFF_FFFF;
                  end else begin
                     r_lo <= r_neg_res ? w_q_neg : r_acc[31:0];
                     r_hi <= r_neg_rem ? w_r_neg : r_acc[63:32];
                  end
               end else begin
                  r_hi <= r_neg_res ? w_prod_neg[63:32] : r_acc[63:32];
                  r_lo <= r_neg_res ? w_prod_neg[31:0]  : r_acc[31:0];
               end
`else
               r_hi <= r_neg_res ? w_prod_neg[63:32] : r_acc[63:32];
               r_lo <= r_neg_res ? w_prod_neg[31:0]  : r_acc[31:0];
`endif
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
//  tb_muldiv_unit : directed scoreboard bench for muldiv_unit
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

   logic clk = 1'b0;
   logic rst_n;

   muldiv_unit_if u_if ();

   muldiv_unit u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
      int          nbusy;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   // Called at a negedge; start is seen at the following posedge
   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      u_if.start = 1'b1;
      u_if.op    = op;
      u_if.a     = a;
      u_if.b     = b;
      @(negedge clk);
      u_if.start = 1'b0;
      u_if.op    = 3'($urandom);
      u_if.a     = $urandom;
      u_if.b     = $urandom;
   endtask

   task automatic collect(input string tag, input int inject_k);
      exp_t        e;
      int          k        = 1;
      int          nb       = 0;
      int          hold_bad = 0;
      logic [31:0] h0       = u_if.hi;
      logic [31:0] l0       = u_if.lo;
      while (u_if.done !== 1'b1 && k < 60) begin
         if (u_if.busy === 1'b1) nb++;
         if (u_if.hi !== h0 || u_if.lo !== l0) hold_bad++;
         if (k == inject_k) begin
            u_if.start = 1'b1;
            u_if.op    = 3'b101;
            u_if.a     = 32'hDEAD_BEEF;
         end
         @(negedge clk);
         u_if.start = 1'b0;
         k++;
      end
      e = sb.pop_front();
      chk({tag, " done"},    {31'd0, u_if.done}, 32'd1);
      chk({tag, " latency"}, 32'(k),             32'(e.lat));
      chk({tag, " busycyc"}, 32'(nb),            32'(e.nbusy));
      chk({tag, " busy@done"}, {31'd0, u_if.busy}, 32'd0);
      chk({tag, " hold"},    32'(hold_bad),      32'd0);
      chk({tag, " hi"},      u_if.hi,            e.hi);
      chk({tag, " lo"},      u_if.lo,            e.lo);
   endtask

   task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                      input int lat, input int nbusy, input int inject_k);
      exp_t e;
      e.hi = ehi; e.lo = elo; e.lat = lat; e.nbusy = nbusy;
      sb.push_back(e);
      drive(op, a, b);
      collect(tag, inject_k);
   endtask

   initial begin : main
      int seen;
      rst_n      = 1'b0;
      u_if.start = 1'b0;
      u_if.op    = 3'b000;
      u_if.a     = 32'd0;
      u_if.b     = 32'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset busy", {31'd0, u_if.busy}, 32'd0);
      chk("reset done", {31'd0, u_if.done}, 32'd0);
      chk("reset hi",   u_if.hi, 32'd0);
      chk("reset lo",   u_if.lo, 32'd0);

      run("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34, 33, 0);
      run("mult_neg",  3'b000, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 34, 33, 0);
      run("mthi",      3'b100, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFEB, 1, 0, 0);
      run("mtlo",      3'b101, 32'hCAFE_F00D, 32'd0,         32'h1234_5678, 32'hCAFE_F00D, 1, 0, 0);

`ifdef MULDIV_DIV_EN
      run("div_neg",   3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 33, 0);
      run("divu_7_2",  3'b011, 32'd7,         32'd2,         32'd1,         32'd3,         34, 33, 0);
      run("div_negb",  3'b010, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 34, 33, 0);
      run("divu_by0",  3'b011, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 34, 33, 0);
      run("div_ovf",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 34, 33, 0);
`else
      run("divu_off",  3'b011, 32'd7,         32'd2,         32'd0,         32'd0,         1, 0, 0);
      run("mthi_re",   3'b100, 32'h0BAD_F00D, 32'd0,         32'h0BAD_F00D, 32'd0,         1, 0, 0);
      run("div_off",   3'b010, 32'hFFFF_FFF9, 32'd2,         32'd0,         32'd0,         1, 0, 0);
`endif

      run("multu_3x4", 3'b001, 32'd3, 32'd4, 32'd0, 32'd12, 34, 33, 0);
      run("mult_busy", 3'b000, 32'd6, 32'd7, 32'd0, 32'd42, 34, 33, 5);
      @(negedge clk);
      chk("single done pulse", {31'd0, u_if.done}, 32'd0);

      // Reserved opcode must leave everything untouched
      drive(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      seen = 0;
      repeat (3) begin
         if (u_if.done === 1'b1 || u_if.busy === 1'b1) seen++;
         @(negedge clk);
      end
      chk("op110 quiet", 32'(seen), 32'd0);
      chk("op110 lo",    u_if.lo,   32'd42);

      run("mthi_pre", 3'b100, 32'hA5A5_A5A5, 32'd0, 32'hA5A5_A5A5, 32'd42, 1, 0, 0);

`ifdef MULDIV_DIV_EN
      drive(3'b010, 32'd100, 32'd3);
`else
      drive(3'b000, 32'd100, 32'd3);
`endif
      repeat (9) @(negedge clk);
      chk("pre-reset busy", {31'd0, u_if.busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst busy", {31'd0, u_if.busy}, 32'd0);
      chk("rst done", {31'd0, u_if.done}, 32'd0);
      chk("rst hi",   u_if.hi, 32'd0);
      chk("rst lo",   u_if.lo, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (u_if.done === 1'b1 || u_if.busy === 1'b1) seen++;
      end
      chk("no done after reset", 32'(seen), 32'd0);

      run("post_rst", 3'b001, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 34, 33, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
